// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-deep pipeline register chain with per-stage valid bits,
// per-stage stall and flush, upstream stall propagation, automatic bubble
// insertion behind held stages and optional sticky (deferred) flushes.
//
// Parameters:
//   WIDTH        payload bits per stage
//   DEPTH        number of register stages
//   BUBBLE_DATA  payload loaded on reset, flush or bubble insertion
//   STICKY_FLUSH 1: flush seen while a stage is held is remembered and applied
//                   on the first edge the stage is released
//                0: flush seen while a stage is held is dropped
//
// Ports:
//   clk_i          clock, all state updates on posedge
//   rst_i          synchronous active-low reset
//   valid_i        upstream payload valid
//   data_i         upstream payload
//   stall_i        per-stage hold request (bit k = stage k)
//   flush_i        per-stage flush request (bit k = stage k)
//   valid_o        last stage valid
//   data_o         last stage payload
//   stage_valid_o  valid bit of every stage
//   stage_data_o   payload of every stage, stage k at [k*WIDTH +: WIDTH]
//   flush_pend_o   latched pending flush per stage
//   occupancy_o    number of valid stages
//   in_ready_o     stage 0 is not held; upstream payload is taken this edge
module pipe_reg_chain #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      DEPTH        = 2,
  parameter logic [WIDTH-1:0] BUBBLE_DATA  = '0,
  parameter bit               STICKY_FLUSH = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic [DEPTH-1:0]             stall_i,
  input  logic [DEPTH-1:0]             flush_i,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             data_o,
  output logic [DEPTH-1:0]             stage_valid_o,
  output logic [DEPTH*WIDTH-1:0]       stage_data_o,
  output logic [DEPTH-1:0]             flush_pend_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         in_ready_o
);

  localparam int unsigned DataW = DEPTH * WIDTH;
  localparam int unsigned OccW  = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DataW-1:0] data_q, data_d;
  logic [DEPTH-1:0] pend_q, pend_d;

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] up_hold;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] src_valid;
  logic [DataW-1:0] src_data;

  // A stall anywhere downstream holds every stage upstream of it.
  always_comb begin : hold_chain
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      acc     = acc | stall_i[k];
      hold[k] = acc;
    end
  end

  // up_hold[k] = hold[k-1]; stage 0 has no upstream register.
  assign up_hold = hold << 1;
  assign kill    = flush_i | pend_q;

  // Source of stage k is stage k-1; stage 0 takes the upstream inputs.
  assign src_valid = (valid_q << 1) | DEPTH'(valid_i);
  assign src_data  = (data_q << WIDTH) | DataW'(data_i);

  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    pend_d  = pend_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (hold[k]) begin
        // Held entry is kept as is; a sticky flush waits for the release.
        if (STICKY_FLUSH && flush_i[k]) begin
          pend_d[k] = 1'b1;
        end
      end else if (kill[k]) begin
        valid_d[k]                 = 1'b0;
        data_d[k*WIDTH +: WIDTH]   = BUBBLE_DATA;
        pend_d[k]                  = 1'b0;
      end else if (up_hold[k]) begin
        // Upstream is held, so taking its contents would duplicate them.
        valid_d[k]                 = 1'b0;
        data_d[k*WIDTH +: WIDTH]   = BUBBLE_DATA;
      end else begin
        valid_d[k]                 = src_valid[k];
        data_d[k*WIDTH +: WIDTH]   = src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      data_q  <= {DEPTH{BUBBLE_DATA}};
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin : pop_count
    occupancy_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occupancy_o = occupancy_o + OccW'(valid_q[k]);
    end
  end

  assign valid_o       = valid_q[DEPTH-1];
  assign data_o        = data_q[(DEPTH-1)*WIDTH +: WIDTH];
  assign stage_valid_o = valid_q;
  assign stage_data_o  = data_q;
  assign flush_pend_o  = pend_q;
  assign in_ready_o    = ~hold[0];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: two instances (sticky and legacy flush) share the
// same stimulus; a behavioural model tracks both, and hand-written sequences
// check fixed expected values for the documented corner cases.
module tb_pipe_reg_chain;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;
  localparam logic [7:0] Bub = 8'h13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic [2:0] stall;
  logic [2:0] flush;

  // Index 0 = sticky instance, index 1 = legacy instance.
  logic        vo       [2];
  logic [7:0]  dout     [2];
  logic [2:0]  st_valid [2];
  logic [23:0] st_data  [2];
  logic [2:0]  fpend    [2];
  logic [1:0]  occ      [2];
  logic        rdy      [2];

  pipe_reg_chain #(
    .WIDTH(W), .DEPTH(D), .BUBBLE_DATA(Bub), .STICKY_FLUSH(1'b1)
  ) dut_sticky (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .data_i(data_in),
    .stall_i(stall), .flush_i(flush), .valid_o(vo[0]), .data_o(dout[0]),
    .stage_valid_o(st_valid[0]), .stage_data_o(st_data[0]),
    .flush_pend_o(fpend[0]), .occupancy_o(occ[0]), .in_ready_o(rdy[0])
  );

  pipe_reg_chain #(
    .WIDTH(W), .DEPTH(D), .BUBBLE_DATA(Bub), .STICKY_FLUSH(1'b0)
  ) dut_legacy (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .data_i(data_in),
    .stall_i(stall), .flush_i(flush), .valid_o(vo[1]), .data_o(dout[1]),
    .stage_valid_o(st_valid[1]), .stage_data_o(st_data[1]),
    .flush_pend_o(fpend[1]), .occupancy_o(occ[1]), .in_ready_o(rdy[1])
  );

  // Reference model state: per instance, per stage.
  logic       mv [2][3];
  logic [7:0] md [2][3];
  logic       mp [2][3];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Apply one clock edge of the rules to the model (instance 0 sticky).
  task automatic model_edge(input logic r, input logic v, input logic [7:0] d,
                            input logic [2:0] st, input logic [2:0] fl);
    logic       src_v [4];
    logic [7:0] src_d [4];
    logic       held  [3];
    logic       up    [4];
    for (int s = 0; s < 2; s++) begin
      src_v[0] = v;
      src_d[0] = d;
      up[0]    = 1'b0;
      for (int k = 0; k < 3; k++) begin
        src_v[k+1] = mv[s][k];
        src_d[k+1] = md[s][k];
        held[k]    = ((st >> k) != 3'b000);
        up[k+1]    = held[k];
      end
      for (int k = 0; k < 3; k++) begin
        if (!r) begin
          mv[s][k] = 1'b0; md[s][k] = Bub; mp[s][k] = 1'b0;
        end else if (held[k]) begin
          if (s == 0 && fl[k]) mp[s][k] = 1'b1;
        end else if (fl[k] || mp[s][k]) begin
          mv[s][k] = 1'b0; md[s][k] = Bub; mp[s][k] = 1'b0;
        end else if (up[k]) begin
          mv[s][k] = 1'b0; md[s][k] = Bub;
        end else begin
          mv[s][k] = src_v[k]; md[s][k] = src_d[k];
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    int cnt;
    for (int s = 0; s < 2; s++) begin
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s i%0d stage%0d valid", tag, s, k), st_valid[s][k], mv[s][k]);
        check($sformatf("%s i%0d stage%0d data", tag, s, k), st_data[s][k*8 +: 8], md[s][k]);
        check($sformatf("%s i%0d stage%0d pend", tag, s, k), fpend[s][k], mp[s][k]);
        cnt += int'(mv[s][k]);
      end
      check($sformatf("%s i%0d occupancy", tag, s), occ[s], cnt);
      check($sformatf("%s i%0d valid_o", tag, s), vo[s], mv[s][2]);
      check($sformatf("%s i%0d data_o", tag, s), dout[s], md[s][2]);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic [2:0] st, input logic [2:0] fl, input string tag);
    rst      = r;
    valid_in = v;
    data_in  = d;
    stall    = st;
    flush    = fl;
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s i%0d in_ready", tag, s), rdy[s], st == 3'b000);
    end
    @(posedge clk);
    model_edge(r, v, d, st, fl);
    #1;
    check_model(tag);
  endtask

  task automatic expect_stage(input int s, input int k, input logic v, input logic [7:0] d,
                              input string tag);
    check($sformatf("%s i%0d stage%0d valid", tag, s, k), st_valid[s][k], v);
    check($sformatf("%s i%0d stage%0d data", tag, s, k), st_data[s][k*8 +: 8], d);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       exp_vo;
    logic [7:0] exp_do;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t tbl [6];

  initial begin
    // Streaming 0x11, 0x22, 0x33 from reset, then idle.
    tbl[0] = '{v: 1'b1, d: 8'h11, exp_vo: 1'b0, exp_do: Bub,   exp_occ: 2'd1};
    tbl[1] = '{v: 1'b1, d: 8'h22, exp_vo: 1'b0, exp_do: Bub,   exp_occ: 2'd2};
    tbl[2] = '{v: 1'b1, d: 8'h33, exp_vo: 1'b1, exp_do: 8'h11, exp_occ: 2'd3};
    tbl[3] = '{v: 1'b0, d: 8'h00, exp_vo: 1'b1, exp_do: 8'h22, exp_occ: 2'd2};
    tbl[4] = '{v: 1'b0, d: 8'h00, exp_vo: 1'b1, exp_do: 8'h33, exp_occ: 2'd1};
    tbl[5] = '{v: 1'b0, d: 8'h00, exp_vo: 1'b0, exp_do: 8'h00, exp_occ: 2'd0};

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        mv[s][k] = 1'b0; md[s][k] = 8'h00; mp[s][k] = 1'b0;
      end
    end

    step(1'b0, 1'b0, 8'h00, 3'b000, 3'b000, "reset");
    step(1'b0, 1'b1, 8'hFF, 3'b000, 3'b111, "reset2");
    check("reset data_o", dout[0], Bub);
    check("reset valid_o", vo[0], 1'b0);
    check("reset occupancy", occ[0], 2'd0);
    check("reset flush_pend", fpend[0], 3'b000);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].v, tbl[i].d, 3'b000, 3'b000, $sformatf("stream%0d", i));
      for (int s = 0; s < 2; s++) begin
        check($sformatf("tbl%0d i%0d valid_o", i, s), vo[s], tbl[i].exp_vo);
        check($sformatf("tbl%0d i%0d data_o", i, s), dout[s], tbl[i].exp_do);
        check($sformatf("tbl%0d i%0d occupancy", i, s), occ[s], tbl[i].exp_occ);
      end
    end

    // Last stage stalled for two cycles with the pipe full.
    step(1'b1, 1'b1, 8'h41, 3'b000, 3'b000, "fill41");
    step(1'b1, 1'b1, 8'h42, 3'b000, 3'b000, "fill42");
    step(1'b1, 1'b1, 8'h43, 3'b000, 3'b000, "fill43");
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 8'h44, 3'b100, 3'b000, "stall2");
      check("stall2 data_o", dout[0], 8'h41);
      check("stall2 in_ready", rdy[0], 1'b0);
      expect_stage(0, 0, 1'b1, 8'h43, "stall2");
      expect_stage(0, 1, 1'b1, 8'h42, "stall2");
    end
    step(1'b1, 1'b1, 8'h44, 3'b000, 3'b000, "rel2");
    check("rel2 data_o", dout[0], 8'h42);
    step(1'b1, 1'b0, 8'h00, 3'b000, 3'b000, "drain1");
    check("drain1 data_o", dout[0], 8'h43);
    step(1'b1, 1'b0, 8'h00, 3'b000, 3'b000, "drain2");
    check("drain2 data_o", dout[0], 8'h44);
    check("drain2 valid_o", vo[0], 1'b1);

    // Stage 0 stalled for one cycle while streaming 0xA1, 0xA2.
    step(1'b1, 1'b1, 8'hA1, 3'b000, 3'b000, "a1");
    step(1'b1, 1'b1, 8'hA2, 3'b001, 3'b000, "a2held");
    expect_stage(0, 0, 1'b1, 8'hA1, "a2held");
    expect_stage(0, 1, 1'b0, Bub, "a2held");
    step(1'b1, 1'b1, 8'hA2, 3'b000, 3'b000, "a2");
    expect_stage(0, 0, 1'b1, 8'hA2, "a2");
    expect_stage(0, 1, 1'b1, 8'hA1, "a2");
    expect_stage(0, 2, 1'b0, Bub, "a2");
    step(1'b1, 1'b0, 8'h00, 3'b000, 3'b000, "a2late");
    expect_stage(0, 1, 1'b1, 8'hA2, "a2late");

    // Flush and stall on stage 1 together, stall released next cycle.
    step(1'b1, 1'b1, 8'h51, 3'b000, 3'b000, "fill51");
    step(1'b1, 1'b1, 8'h52, 3'b000, 3'b000, "fill52");
    step(1'b1, 1'b1, 8'h53, 3'b000, 3'b000, "fill53");
    step(1'b1, 1'b1, 8'h54, 3'b010, 3'b010, "sfl");
    check("sfl sticky pend", fpend[0], 3'b010);
    check("sfl legacy pend", fpend[1], 3'b000);
    expect_stage(0, 1, 1'b1, 8'h52, "sfl");
    expect_stage(0, 2, 1'b0, Bub, "sfl");
    step(1'b1, 1'b1, 8'h54, 3'b000, 3'b000, "sflrel");
    expect_stage(0, 1, 1'b0, Bub, "sflrel");
    check("sflrel sticky pend", fpend[0], 3'b000);
    expect_stage(1, 1, 1'b1, 8'h53, "sflrel");
    expect_stage(0, 2, 1'b1, 8'h52, "sflrel");

    // Flush every stage of a full pipe.
    step(1'b1, 1'b1, 8'h61, 3'b000, 3'b000, "fill61");
    step(1'b1, 1'b1, 8'h62, 3'b000, 3'b000, "fill62");
    step(1'b1, 1'b1, 8'h63, 3'b000, 3'b000, "fill63");
    step(1'b1, 1'b0, 8'h00, 3'b000, 3'b111, "flushall");
    check("flushall occupancy", occ[0], 2'd0);
    check("flushall stage data", st_data[0], {3{Bub}});
    check("flushall stage valid", st_valid[0], 3'b000);

    // Reset with the pipe full and a flush pending.
    step(1'b1, 1'b1, 8'h71, 3'b000, 3'b000, "fill71");
    step(1'b1, 1'b1, 8'h72, 3'b000, 3'b000, "fill72");
    step(1'b1, 1'b1, 8'h73, 3'b000, 3'b000, "fill73");
    step(1'b1, 1'b0, 8'h00, 3'b100, 3'b100, "pendfull");
    check("pendfull occupancy", occ[0], 2'd3);
    check("pendfull pend", fpend[0], 3'b100);
    step(1'b0, 1'b1, 8'h74, 3'b100, 3'b100, "rstpend");
    check("rstpend occupancy", occ[0], 2'd0);
    check("rstpend pend", fpend[0], 3'b000);
    check("rstpend stage valid", st_valid[0], 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b000, 3'b000, "postrst");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [2:0] st;
      logic [2:0] fl;
      r  = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      fl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      step(r, 1'($urandom), 8'($urandom), st, fl, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
